// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write bus between a byte source and prog_loader.
// The source side (UART/debug bridge or bench) uses the master modport; the loader uses slave.
interface prog_loader_if #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned COMBINED_DATA = 24
);
  logic                     start;
  logic [7:0]               byte_in;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [COMBINED_DATA-1:0] wr_data;
  logic                     core_rst_n;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, core_rst_n, busy, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, core_rst_n, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs a framed byte stream (count, data bytes, checksum) into instruction
// words, writes them to program memory from address 0 and releases the core reset on success.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned REG_BIT_CNT    = 3,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned COMBINED_DATA  = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH,
  parameter int unsigned BYTES_PER_WORD = (COMBINED_DATA + 7) / 8
) (
  input logic            clk,
  input logic            rst,
  prog_loader_if.slave   bus
);

  localparam int unsigned WordBits = BYTES_PER_WORD * 8;
  localparam int unsigned IdxW     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned MaxWords = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW     = ADDR_WIDTH + 1;

  localparam logic [IdxW-1:0]       IdxLast = IdxW'(BYTES_PER_WORD - 1);
  localparam logic [IdxW-1:0]       IdxOne  = IdxW'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [CntW-1:0]       CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle, StCount, StData, StWrite, StCheck, StDone, StError
  } state_e;

  state_e                state_q, state_d;
  logic [WordBits-1:0]   word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [7:0]            xor_q, xor_d;

  logic xfer;
  logic count_ok;
  logic last_word;

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign count_ok  = (bus.byte_in != 8'd0) && (32'(bus.byte_in) <= MaxWords);
  // Address never wraps: the final word is the one at N-1.
  assign last_word = (({1'b0, addr_q} + CntOne) == cnt_q);

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
    end
  end

  // Next-state and datapath update for the frame parser.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (bus.start) begin
          state_d = StCount;
          word_d  = '0;
          addr_d  = '0;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      StCount: begin
        if (xfer) begin
          xor_d   = xor_q ^ bus.byte_in;
          cnt_d   = CntW'(bus.byte_in);
          state_d = count_ok ? StData : StError;
        end
      end
      StData: begin
        if (xfer) begin
          xor_d  = xor_q ^ bus.byte_in;
          // MSB byte first; pad bits of the first byte fall off the top of wr_data.
          word_d = (word_q << 8) | WordBits'(bus.byte_in);
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = StWrite;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end
      end
      StWrite: begin
        if (last_word) begin
          state_d = StCheck;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StData;
        end
      end
      StCheck: begin
        if (xfer) begin
          state_d = (bus.byte_in == xor_q) ? StDone : StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register and datapath registers.
  always_comb begin
    bus.byte_ready = (state_q == StCount) || (state_q == StData) || (state_q == StCheck);
    bus.wr_en      = (state_q == StWrite);
    bus.wr_addr    = addr_q;
    bus.wr_data    = word_q[COMBINED_DATA-1:0];
    bus.core_rst_n = (state_q == StDone);
    bus.busy       = (state_q == StCount) || (state_q == StData) ||
                     (state_q == StWrite) || (state_q == StCheck);
    bus.done       = (state_q == StDone);
    bus.err        = (state_q == StError);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus, a negedge
// monitor pops and compares each wr_en strobe; session status is checked after each frame.
module tb_prog_loader;
  localparam int unsigned AW = 5;
  localparam int unsigned RB = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned CD = AW + RB + DW;

  typedef struct {
    logic [AW-1:0] a;
    logic [CD-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_WIDTH(AW), .COMBINED_DATA(CD)) bus ();

  prog_loader #(
    .ADDR_WIDTH (AW),
    .REG_BIT_CNT(RB),
    .DATA_WIDTH (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wr_t        exp_q[$];
  logic [7:0] frame[$];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      check("ready_low_in_write", {31'b0, bus.byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, bus.wr_en}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e.a));
        check("wr_data", 32'(bus.wr_data), 32'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold);
    bit acc;
    acc = 1'b0;
    if (!hold) repeat ($urandom_range(0, 2)) tick();
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = bus.byte_ready;
      tick();
    end
    if (!acc) check("byte_accept_timeout", {31'b0, acc}, 32'd1);
    if (!hold) bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input bit hold);
    foreach (frame[i]) send_byte(frame[i], hold);
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    check("done_cleared", {31'b0, bus.done}, 32'd0);
    check("err_cleared", {31'b0, bus.err}, 32'd0);
  endtask

  task automatic check_status(input string tag, input bit d, input bit e, input bit c);
    check({tag, "_done"}, {31'b0, bus.done}, {31'b0, d});
    check({tag, "_err"}, {31'b0, bus.err}, {31'b0, e});
    check({tag, "_core_rst_n"}, {31'b0, bus.core_rst_n}, {31'b0, c});
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_ready"}, {31'b0, bus.byte_ready}, 32'd0);
  endtask

  task automatic check_drained(input string tag);
    repeat (2) tick();
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_test1_frame(input logic [7:0] chk);
    frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, chk};
    exp_q.push_back('{a: 5'd0, d: 24'h123456});
    exp_q.push_back('{a: 5'd1, d: 24'hABCDEF});
  endtask

  task automatic check_all_reset();
    check("rst_ready", {31'b0, bus.byte_ready}, 32'd0);
    check("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_core_rst_n", {31'b0, bus.core_rst_n}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    rst            = 1'b1;
    repeat (3) tick();
    check_all_reset();
    rst = 1'b0;
    tick();

    // 1: good two-word frame.
    do_start();
    load_test1_frame(8'hFB);
    send_frame(1'b0);
    check_status("t1", 1'b1, 1'b0, 1'b1);
    check_drained("t1");

    // 2: same frame, bad checksum; writes still happen.
    do_start();
    load_test1_frame(8'h00);
    send_frame(1'b0);
    check_status("t2", 1'b0, 1'b1, 1'b0);
    check_drained("t2");

    // 3: invalid counts 0 and 33.
    do_start();
    frame = '{8'h00};
    send_frame(1'b0);
    check_status("t3a", 1'b0, 1'b1, 1'b0);
    bus.byte_valid = 1'b1;
    repeat (3) tick();
    bus.byte_valid = 1'b0;
    do_start();
    frame = '{8'h21};
    send_frame(1'b0);
    check_status("t3b", 1'b0, 1'b1, 1'b0);
    check_drained("t3");

    // 4: byte_valid held high across the whole frame, including WRITE cycles.
    do_start();
    load_test1_frame(8'hFB);
    send_frame(1'b1);
    check_status("t4", 1'b1, 1'b0, 1'b1);
    check_drained("t4");

    // 5: reset after four accepted bytes (word 0 write is in flight), then a clean reload.
    do_start();
    frame = '{8'h02, 8'h12, 8'h34, 8'h56};
    exp_q.push_back('{a: 5'd0, d: 24'h123456});
    send_frame(1'b0);
    rst = 1'b1;
    tick();
    check_all_reset();
    rst = 1'b0;
    tick();
    check_drained("t5a");
    do_start();
    load_test1_frame(8'hFB);
    send_frame(1'b0);
    check_status("t5", 1'b1, 1'b0, 1'b1);
    check_drained("t5");

    // 6: full capacity, 32 words at addresses 0..31.
    do_start();
    frame = '{8'h20};
    x = 8'h20;
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b0, b1, b2;
      b0 = 8'(i);
      b1 = 8'(i * 7 + 3);
      b2 = ~8'(i);
      frame.push_back(b0);
      frame.push_back(b1);
      frame.push_back(b2);
      x = x ^ b0 ^ b1 ^ b2;
      exp_q.push_back('{a: 5'(i), d: {b0, b1, b2}});
    end
    frame.push_back(x);
    send_frame(1'b0);
    check_status("t6", 1'b1, 1'b0, 1'b1);
    check_drained("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
